// File: rtl/mul_operand_sequencer.sv
// Operand front-end for the repeated-addition multiplier: buffers {a,b} pairs,
// sequences start/A/B over the shared load bus, and returns product or timeout error.
module mul_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 600
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_err,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_data,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // A zero operand makes the product trivially zero, so the multiplier is skipped.
    function automatic logic is_bypass(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   fifo_a_r [2];
    logic [WIDTH-1:0]   fifo_b_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [TW-1:0]      timer_r;
    logic               out_valid_r;
    logic [2*WIDTH-1:0] out_product_r;
    logic               out_err_r;
    logic               mul_start_r;
    logic [WIDTH-1:0]   mul_data_r;

    logic               push_s;
    logic               pop_s;
    logic [WIDTH-1:0]   head_a_s;
    logic [WIDTH-1:0]   head_b_s;

    // FIFO handshake qualifiers and head-of-queue view.
    always_comb begin
        push_s   = in_valid && (count_r != 2'd2);
        pop_s    = (state_r == S_IDLE) && (count_r != 2'd0);
        head_a_s = fifo_a_r[rd_ptr_r];
        head_b_s = fifo_b_r[rd_ptr_r];
    end

    // Two-entry operand FIFO; pops happen only on the idle-exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_a_r[0] <= {WIDTH{1'b0}};
            fifo_a_r[1] <= {WIDTH{1'b0}};
            fifo_b_r[0] <= {WIDTH{1'b0}};
            fifo_b_r[1] <= {WIDTH{1'b0}};
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_a_r[wr_ptr_r] <= in_a;
                fifo_b_r[wr_ptr_r] <= in_b;
                wr_ptr_r           <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencing FSM with all multiplier-side and result-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            op_b_r        <= {WIDTH{1'b0}};
            timer_r       <= {TW{1'b0}};
            out_valid_r   <= 1'b0;
            out_product_r <= {(2*WIDTH){1'b0}};
            out_err_r     <= 1'b0;
            mul_start_r   <= 1'b0;
            mul_data_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        op_b_r <= head_b_s;
                        if (is_bypass(head_a_s, head_b_s)) begin
                            out_product_r <= {(2*WIDTH){1'b0}};
                            out_err_r     <= 1'b0;
                            out_valid_r   <= 1'b1;
                            state_r       <= S_OUT;
                        end else begin
                            mul_start_r <= 1'b1;
                            mul_data_r  <= head_a_s;
                            state_r     <= S_A;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_A: begin
                    mul_start_r <= 1'b0;
                    mul_data_r  <= op_b_r;
                    state_r     <= S_B;
                end
                S_B: begin
                    timer_r <= {TW{1'b0}};
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        out_product_r <= mul_product;
                        out_err_r     <= 1'b0;
                        out_valid_r   <= 1'b1;
                        state_r       <= S_OUT;
                    end else if (timer_r == TIMER_LAST) begin
                        // Missing done: report an error result instead of hanging.
                        out_product_r <= {(2*WIDTH){1'b0}};
                        out_err_r     <= 1'b1;
                        out_valid_r   <= 1'b1;
                        state_r       <= S_OUT;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_OUT;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    mul_start_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (count_r != 2'd2);
    assign busy        = (state_r != S_IDLE) || (count_r != 2'd0);
    assign out_valid   = out_valid_r;
    assign out_product = out_product_r;
    assign out_err     = out_err_r;
    assign mul_start   = mul_start_r;
    assign mul_data    = mul_data_r;

endmodule
